// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and programmable bit period.
// Define UART_TX_PARITY_EN to append an even-parity bit (8E1 frames).
module uart_tx_port #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic [15:0]   div_q;

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          txd_q, txd_d;

  logic [1:0]    sel;
  logic          push_req, push_ok, pop;
  logic          fifo_empty, fifo_full, busy, tick;
  logic [15:0]   reload;
  logic [7:0]    head;

  logic          unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:16]};

  assign sel        = addr[3:2];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign push_req   = wen && (sel == 2'd0);
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign head       = mem_q[rptr_q];
  assign busy       = (state_q != S_IDLE);
  assign tick       = (cnt_q == 16'd0);
  assign reload     = ((div_q == 16'd0) ? 16'd1 : div_q) - 16'd1;
  assign txd        = txd_q;

  always_comb begin
    rdata = 32'd0;
    case (sel)
      2'd1:    rdata = {26'd0, ovf_q, busy, fifo_full, fifo_empty, count_q[1:0]};
      2'd2:    rdata = {16'd0, div_q};
      default: rdata = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    if (state_q != S_IDLE) cnt_d = cnt_q - 16'd1;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = head;
          state_d = S_START;
          cnt_d   = reload;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          cnt_d   = reload;
          txd_d   = data_q[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d = reload;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = ^data_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = data_q[bit_d];
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          cnt_d   = reload;
          txd_d   = 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          // Chain straight into the next start bit so frames stay contiguous.
          if (!fifo_empty) begin
            pop     = 1'b1;
            data_d  = head;
            state_d = S_START;
            cnt_d   = reload;
            txd_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      txd_q   <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      div_q   <= DIV_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push_req && fifo_full && !pop)
        ovf_q <= 1'b1;
      else if (wen && (sel == 2'd1) && wdata[5])
        ovf_q <= 1'b0;
      if (wen && (sel == 2'd2)) div_q <= wdata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    if (push_ok) mem_q[wptr_q] <= wdata[7:0];
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port: register map, frame shape, FIFO overflow,
// mid-frame divisor change and mid-frame reset.
module tb_uart_tx_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        txd;

  int n_chk = 0;
  int n_err = 0;

  uart_tx_port #(.FIFO_DEPTH(8), .DIV_RESET(16'd4)) dut (
    .clk   (clk),
    .rst   (rst),
    .wen   (wen),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .txd   (txd)
  );

  always #5 clk = ~clk;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == NBITS - 1) return 1'b1;
    return ^b;
  endfunction

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wen = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wen = 1'b0; addr = 32'h4;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  // act: 0 none, 1 write DIV=div_b at first cycle of frame bit act_at, 2 assert reset there.
  task automatic check_frame(input logic [7:0] b, input int div_a, input int act,
                             input int act_at, input int div_b);
    int dur;
    for (int i = 0; i < NBITS; i++) begin
      dur = (act == 1 && i > act_at) ? div_b : div_a;
      for (int j = 0; j < dur; j++) begin
        @(negedge clk);
        wen = 1'b0; addr = 32'h4;
        #1;
        chk($sformatf("f%02h_bit%0d_c%0d", b, i, j), {31'd0, txd}, {31'd0, exp_bit(b, i)});
        if (j == 0) chk($sformatf("f%02h_busy%0d", b, i), {31'd0, rdata[4]}, 32'd1);
        if (act == 1 && i == act_at && j == 0) begin
          wen = 1'b1; addr = 32'h8; wdata = div_b;
        end
        if (act == 2 && i == act_at && j == 1) begin
          rst = 1'b1;
          return;
        end
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int lows;
    rst = 1'b1; wen = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_txd", {31'd0, txd}, 32'd1);
    rd(32'h4, v);  chk("rst_status", v, 32'h04);
    rd(32'h8, v);  chk("rst_div", v, 32'h4);
    rd(32'h0, v);  chk("data_reads0", v, 32'h0);
    rd(32'hC, v);  chk("rsvd_reads0", v, 32'h0);

    bus_wr(32'h8, 32'hFFFF_1234);
    rd(32'h8, v);  chk("div_zext", v, 32'h1234);
    bus_wr(32'hC, 32'hFFFF_FFFF);
    rd(32'h8, v);  chk("rsvd_ignored_div", v, 32'h1234);
    rd(32'hC, v);  chk("rsvd_still0", v, 32'h0);
    rd(32'h4, v);  chk("rsvd_ignored_status", v, 32'h04);
    bus_wr(32'h8, 32'h4);

    // Single frame 0x55
    bus_wr(32'h0, 32'h55);
    #1 chk("pre_start_txd", {31'd0, txd}, 32'd1);
    check_frame(8'h55, 4, 0, 0, 0);
    @(negedge clk);
    rd(32'h4, v);  chk("post55_status", v, 32'h04);

    // Two bytes on consecutive edges: frames must be contiguous
    @(negedge clk);
    wen = 1'b1; addr = 32'h0; wdata = 32'hA3;
    @(negedge clk);
    wdata = 32'h0F;
    check_frame(8'hA3, 4, 0, 0, 0);
    check_frame(8'h0F, 4, 0, 0, 0);
    @(negedge clk);
    rd(32'h4, v);  chk("post_b2b_status", v, 32'h04);

    // DIV 4 -> 8 during data bit 3 (frame bit 4)
    bus_wr(32'h0, 32'hC5);
    check_frame(8'hC5, 4, 1, 4, 8);
    @(negedge clk);
    rd(32'h4, v);  chk("post_divchg_status", v, 32'h04);
    rd(32'h8, v);  chk("divchg_div", v, 32'h8);
    bus_wr(32'h8, 32'h4);

    // 0x07: parity bit is 1 when the parity build is enabled
    bus_wr(32'h0, 32'h07);
    check_frame(8'h07, 4, 0, 0, 0);
    @(negedge clk);
    rd(32'h4, v);  chk("post07_status", v, 32'h04);

    // Reset during data bit 5 (frame bit 6) with a second byte queued
    @(negedge clk);
    wen = 1'b1; addr = 32'h0; wdata = 32'h5A;
    @(negedge clk);
    wdata = 32'h3C;
    check_frame(8'h5A, 4, 2, 6, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_txd", {31'd0, txd}, 32'd1);
    rd(32'h4, v);  chk("midrst_status", v, 32'h04);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      #1;
      if (txd !== 1'b1) lows++;
    end
    chk("midrst_no_frame", lows, 0);

    // Overflow: stall with DIV=100, push 10 bytes
    bus_wr(32'h8, 32'd100);
    for (int k = 0; k < 10; k++) bus_wr(32'h0, 32'(k));
    rd(32'h4, v);  chk("ovf_status", v, 32'h38);
    bus_wr(32'h4, 32'h20);
    rd(32'h4, v);  chk("ovf_cleared", v, 32'h18);
    rd(32'h8, v);  chk("ovf_div", v, 32'd100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("final_rst_txd", {31'd0, txd}, 32'd1);
    rd(32'h4, v);  chk("final_rst_status", v, 32'h04);
    rd(32'h8, v);  chk("final_rst_div", v, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
